// File: rtl/wwd_output_drain.sv
// wwd_output_drain: queues WWD output words for an external device and turns HLT into a clean halt once all words have been delivered.
// Optional feature macro WWD_COUNT_EN adds a 16-bit wwd_count port that counts delivered words.
module wwd_output_drain #(
   parameter int WORD_SIZE = 16,
   parameter int DEPTH     = 4,
   parameter int PTR_W     = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wwd_en,
   input  logic [WORD_SIZE-1:0] wwd_data,
   input  logic                 hlt_req,
   output logic                 stall_req,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] out_data,
   input  logic                 out_ready,
   output logic                 is_halted
`ifdef WWD_COUNT_EN
   ,
   output logic [15:0]          wwd_count
`endif
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   logic [WORD_SIZE-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]     rd_q, rd_d, wr_q, wr_d;
   logic [PTR_W:0]       count_q, count_d;
   state_t               state_q, state_d;
   logic [WORD_SIZE-1:0] out_data_q, out_data_d;
   logic                 out_valid_q, is_halted_q;
   logic                 run, full, pop, push;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign is_halted = is_halted_q;
   // Handshake, pointer/count update and next head word; the head is bypassed from wwd_data when the incoming word lands in the head slot.
   always_comb begin
      run        = state_q == RUN;
      full       = count_q == CNT_FULL;
      pop        = out_valid_q & out_ready;
      push       = wwd_en & run & (!full | pop);
      stall_req  = wwd_en & run & full & !pop;
      rd_d       = pop ? rd_q + PTR_ONE : rd_q;
      wr_d       = push ? wr_q + PTR_ONE : wr_q;
      count_d    = (push & !pop) ? count_q + CNT_ONE : (pop & !push) ? count_q - CNT_ONE : count_q;
      out_data_d = (count_d == '0) ? '0 : (push && rd_d == wr_q) ? wwd_data : mem_q[rd_d];
      state_d    = (run & hlt_req) ? DRAIN : (state_q == DRAIN && count_d == '0) ? HALTED : state_q;
   end
   // Storage array; contents need no reset because pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= wwd_data;
   end
   // Control state, registered outputs and halt FSM; is_halted lags HALTED entry by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q        <= '0;
         wr_q        <= '0;
         count_q     <= '0;
         state_q     <= RUN;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         is_halted_q <= 1'b0;
      end else begin
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         out_valid_q <= count_d != '0;
         out_data_q  <= out_data_d;
         is_halted_q <= state_q == HALTED;
      end
   end
`ifdef WWD_COUNT_EN
   logic [15:0] wwd_count_q;
   assign wwd_count = wwd_count_q;
   // Delivered-word counter; wraps naturally and stops in HALTED since no pops occur there.
   always_ff @(posedge clk) begin
      if (reset) wwd_count_q <= '0;
      else if (pop) wwd_count_q <= wwd_count_q + 16'd1;
   end
`endif
endmodule

// File: tb/tb_wwd_output_drain.sv
// tb_wwd_output_drain: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_wwd_output_drain;
   logic        clk = 1'b0;
   logic        reset, wwd_en, hlt_req, out_ready;
   logic [15:0] wwd_data;
   logic        stall_req, out_valid, is_halted;
   logic [15:0] out_data;
`ifdef WWD_COUNT_EN
   logic [15:0] wwd_count;
`endif
   logic [15:0] exp_q [$];
   int          checks = 0;
   int          failures = 0;

   wwd_output_drain dut (
      .clk(clk), .reset(reset), .wwd_en(wwd_en), .wwd_data(wwd_data), .hlt_req(hlt_req),
      .stall_req(stall_req), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .is_halted(is_halted)
`ifdef WWD_COUNT_EN
      , .wwd_count(wwd_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Monitor: every accepted transfer must match the oldest expected word.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               failures++;
               $display("FAIL drain_order: got %h expected %h", out_data, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; wwd_en = 1'b0; hlt_req = 1'b0; out_ready = 1'b0; wwd_data = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_halted", is_halted, 0);
      chk("rst_stall", stall_req, 0);

      out_ready = 1'b1; wwd_en = 1'b1; wwd_data = 16'h1234; exp_q.push_back(16'h1234);
      tick();
      wwd_en = 1'b0;
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 16'h1234);
      tick();
      chk("single_gone", out_valid, 0);
      chk("empty_data_zero", out_data, 0);

      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         wwd_en = 1'b1; wwd_data = 16'(i); exp_q.push_back(16'(i));
         settle();
         chk("fill_no_stall", stall_req, 0);
         tick();
      end
      wwd_data = 16'h0005; exp_q.push_back(16'h0005);
      settle();
      chk("full_stall", stall_req, 1);
      tick();
      chk("full_stall_hold", stall_req, 1);
      chk("full_head_stable", out_data, 16'h0001);
      out_ready = 1'b1;
      settle();
      chk("full_pop_no_stall", stall_req, 0);
      tick();
      wwd_en = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("drain5_empty", out_valid, 0);
      chk("drain5_sb", exp_q.size(), 0);

      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wwd_en = 1'b1; wwd_data = 16'h0010 + 16'(i); exp_q.push_back(wwd_data);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wwd_data = 16'h0020 + 16'(i); exp_q.push_back(wwd_data);
         settle();
         chk("stream_no_stall", stall_req, 0);
         tick();
      end
      wwd_en = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("stream_empty", out_valid, 0);
      chk("stream_sb", exp_q.size(), 0);

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wwd_en = 1'b1; wwd_data = 16'h00A1 + 16'(i); exp_q.push_back(wwd_data);
         tick();
      end
      wwd_en = 1'b0; hlt_req = 1'b1;
      tick();
      hlt_req = 1'b0;
      chk("drain_not_halted", is_halted, 0);
      tick();
      chk("drain_hold_halted", is_halted, 0);
      chk("drain_hold_valid", out_valid, 1);
      out_ready = 1'b1;
      tick(); tick(); tick();
      chk("drained_valid", out_valid, 0);
      chk("drained_not_yet", is_halted, 0);
      tick();
      chk("halted", is_halted, 1);
      wwd_en = 1'b1; wwd_data = 16'hBEEF;
      settle();
      chk("halted_no_stall", stall_req, 0);
      tick();
      wwd_en = 1'b0;
      chk("halted_no_out", out_valid, 0);
      tick();
      chk("halted_no_out2", out_valid, 0);
      chk("halted_sticky", is_halted, 1);

      out_ready = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_clears_halt", is_halted, 0);
      hlt_req = 1'b1;
      tick();
      hlt_req = 1'b0;
      chk("empty_hlt_1", is_halted, 0);
      tick();
      chk("empty_hlt_2", is_halted, 0);
      tick();
      chk("empty_hlt_3", is_halted, 1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      wwd_en = 1'b1; wwd_data = 16'h0C01; tick();
      wwd_data = 16'h0C02; tick();
      wwd_en = 1'b0; hlt_req = 1'b1;
      tick();
      hlt_req = 1'b0;
      chk("mid_drain_valid", out_valid, 1);
      chk("mid_drain_data", out_data, 16'h0C01);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("drain_rst_valid", out_valid, 0);
      chk("drain_rst_data", out_data, 0);
      chk("drain_rst_halted", is_halted, 0);
      out_ready = 1'b1; wwd_en = 1'b1; wwd_data = 16'h0055; exp_q.push_back(16'h0055);
      tick();
      wwd_en = 1'b0;
      chk("run_after_rst", out_data, 16'h0055);
      tick();
`ifdef WWD_COUNT_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("cnt_rst", wwd_count, 0);
      for (int i = 0; i < 5; i++) begin
         wwd_en = 1'b1; wwd_data = 16'h0E00 + 16'(i); exp_q.push_back(wwd_data);
         tick();
      end
      wwd_en = 1'b0;
      tick(); tick();
      chk("cnt_five", wwd_count, 5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("cnt_rst2", wwd_count, 0);
`endif
      chk("sb_final", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wwd_output_drain.md
Name: wwd_output_drain

Overview:
- Consumer end of the ALU's WWD output path in the 16-bit pipelined CPU.
- Captures each word the execute stage emits on its output port into a small FIFO.
- Presents queued words to the external output device over a valid/ready handshake.
- Turns the ALU halt indication into a clean halt: the CPU reports halted only after every pending WWD word has been delivered.

Parameters:
- WORD_SIZE, 16, data width of output words.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width (count register is PTR_W+1 bits).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wwd_en  input  1  execute stage issues a WWD this cycle.
- wwd_data  input  WORD_SIZE  word to emit (the ALU output_port value).
- hlt_req  input  1  ALU halt indication (isHLT) from a committed HLT.
- stall_req  output  1  pipeline must hold execute stage; combinational.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WORD_SIZE  head-of-FIFO word.
- out_ready  input  1  external device accepts out_data this cycle.
- is_halted  output  1  halt complete; FIFO empty.

Behaviour:
- Reset (reset=1 at a rising edge):
  - Pointers and count cleared; state goes to RUN.
  - out_valid=0, out_data=0, is_halted=0.
  - Applies mid-transfer or mid-drain: queued words are discarded.
- pop = out_valid & out_ready.
- push = wwd_en & (state==RUN) & (!full | pop).
  - A full FIFO accepts a write when it pops in the same cycle.
- stall_req = wwd_en & (state==RUN) & full & !pop.
  - The pipeline re-presents the same wwd_en/wwd_data until the write is accepted.
  - A word is never dropped while stalled.
- Latency: a pushed word appears on out_data/out_valid the cycle after the push edge.
- FIFO order is strict: words leave in push order.
- out_data:
  - Is the stored head entry, registered.
  - Holds stable while out_valid=1 and out_ready=0.
  - Is 0 when the FIFO is empty.
- Pointers wrap modulo DEPTH.
- Count:
  - Increments on push only.
  - Decrements on pop only.
  - Is unchanged on simultaneous push and pop.
  - Never exceeds DEPTH.
- State machine:
  - RUN: normal operation. If hlt_req=1, go to DRAIN. A wwd_en in the same cycle as hlt_req is still pushed, since WWD precedes HLT in program order.
  - DRAIN: wwd_en is ignored (no push, no stall); hlt_req is ignored. Go to HALTED on the edge where count becomes 0, or immediately next edge if already empty.
  - HALTED: is_halted=1 (registered, asserted the cycle after entry). wwd_en and hlt_req are ignored. State holds until reset.
- Empty FIFO with hlt_req: RUN -> DRAIN -> HALTED; is_halted rises exactly 2 cycles after the hlt_req edge.
- out_ready while empty: no effect.

Optional Feature:
- Macro: WWD_COUNT_EN.
- Defined:
  - Adds output port wwd_count (16 bits), reset to 0.
  - Increments by 1 on every pop and wraps from 0xFFFF to 0x0000.
  - Frozen in HALTED (no further pops are possible there).
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then wwd_en with 0x1234 for one cycle and out_ready=1 -> out_valid=1, out_data=0x1234 the next cycle; out_valid=0 the cycle after.
- out_ready=0; push 0x0001..0x0004 -> no stall. A 5th push of 0x0005 -> stall_req=1 and it holds. Raise out_ready -> 0x0005 accepted on the same edge 0x0001 pops; the drained order is 0x0001..0x0005.
- Full FIFO, wwd_en and out_ready both high for 8 cycles with an incrementing data stream -> stall_req=0 throughout, no loss, no reordering.
- Queue 3 words with out_ready=0, then pulse hlt_req -> is_halted stays 0. Release out_ready -> 3 words drain; is_halted=1 the cycle after the FIFO empties. A later wwd_en of 0xBEEF produces no output.
- hlt_req on an empty FIFO -> is_halted=1 exactly 2 cycles later. Assert reset during DRAIN with 2 words queued -> out_valid=0, is_halted=0, state RUN.
- With WWD_COUNT_EN defined, deliver 5 words -> wwd_count=5. Reset -> wwd_count=0.
